// File: rtl/bridge_pkg.sv
// Shared definitions for the serial bridge: tx state encoding, line levels and frame width.
package bridge_pkg;

    localparam int unsigned DEFAULT_DATA_W = 32;

    localparam logic START_BIT = 1'b1;
    localparam logic STOP_BIT  = 1'b0;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

endpackage

// File: rtl/tx_bit_timer.sv
// Bit-period down-counter: bit_tick marks the last clk of each CLKS_PER_BIT-long bit period.
module tx_bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic restart,
    input  logic enable,
    output logic bit_tick
);

    localparam logic [7:0] RELOAD = 8'(CLKS_PER_BIT - 1);

    logic [7:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (restart) begin
            cnt <= RELOAD;
        end else if (enable) begin
            if (cnt == '0) begin
                cnt <= RELOAD;
            end else begin
                cnt <= cnt - 8'd1;
            end
        end
    end

    assign bit_tick = enable && (cnt == '0);

endmodule

// File: rtl/prdata_serializer.sv
// Frames a latched read word as START, MSB-first data, optional even parity, STOP on one line.
// Optional parity bit enabled by defining PRDATA_PARITY_EN.
module prdata_serializer
    import bridge_pkg::*;
#(
    parameter int unsigned DATA_W       = DEFAULT_DATA_W,
    parameter int unsigned CLKS_PER_BIT = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] prdata,
    input  logic              prdata_valid,
    output logic              prdata_ready,
    output logic              data_to_master,
    output logic              tx_busy,
    output logic              tx_done
);

    localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    tx_state_t         state;
    logic [DATA_W-1:0] shreg;
    logic [CNT_W-1:0]  bit_cnt;
    logic              accept;
    logic              bit_tick;
`ifdef PRDATA_PARITY_EN
    logic              parity_bit;
`endif

    assign accept = prdata_valid && prdata_ready;

    tx_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .restart (accept),
        .enable  (state != IDLE),
        .bit_tick(bit_tick)
    );

    // The line register is loaded with the next state's bit at each boundary,
    // so the shifted-out MSB appears one edge after the shift decision.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            shreg          <= '0;
            bit_cnt        <= '0;
            data_to_master <= 1'b0;
            tx_busy        <= 1'b0;
            tx_done        <= 1'b0;
            prdata_ready   <= 1'b1;
`ifdef PRDATA_PARITY_EN
            parity_bit     <= 1'b0;
`endif
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    data_to_master <= 1'b0;
                    if (accept) begin
                        shreg          <= prdata;
`ifdef PRDATA_PARITY_EN
                        parity_bit     <= ^prdata;
`endif
                        state          <= START;
                        data_to_master <= START_BIT;
                        tx_busy        <= 1'b1;
                        prdata_ready   <= 1'b0;
                    end
                end
                START: begin
                    if (bit_tick) begin
                        state          <= DATA;
                        bit_cnt        <= '0;
                        data_to_master <= shreg[DATA_W-1];
                    end
                end
                DATA: begin
                    if (bit_tick) begin
                        if (bit_cnt == LAST_BIT) begin
`ifdef PRDATA_PARITY_EN
                            state          <= PARITY;
                            data_to_master <= parity_bit;
`else
                            state          <= STOP;
                            data_to_master <= STOP_BIT;
`endif
                        end else begin
                            shreg          <= shreg << 1;
                            data_to_master <= shreg[DATA_W-2];
                            bit_cnt        <= bit_cnt + CNT_W'(1);
                        end
                    end
                end
`ifdef PRDATA_PARITY_EN
                PARITY: begin
                    if (bit_tick) begin
                        state          <= STOP;
                        data_to_master <= STOP_BIT;
                    end
                end
`endif
                STOP: begin
                    if (bit_tick) begin
                        state          <= IDLE;
                        data_to_master <= 1'b0;
                        tx_busy        <= 1'b0;
                        tx_done        <= 1'b1;
                        prdata_ready   <= 1'b1;
                    end
                end
                default: begin
                    state          <= IDLE;
                    data_to_master <= 1'b0;
                    tx_busy        <= 1'b0;
                    prdata_ready   <= 1'b1;
                end
            endcase
        end
    end

endmodule
